jt89_vol_ramp: RTL

JT89_VOL_RAMP -- requirements
Module: jt89_vol_ramp

---
 rtl/jt89_pkg.sv | 14 +
 rtl/jt89_vol_ramp_if.sv | 14 +
 rtl/jt89_vol_ch.sv | 59 +++++
 rtl/jt89_vol_ramp.sv | 62 ++++++
 4 files changed

// File: rtl/jt89_pkg.sv
// Shared constants for the JT89 volume ramp: 2 dB attenuation curve and mute code.
package jt89_pkg;

   localparam logic [3:0] ATT_MUTE = 4'd15;

   // Index 0 (loudest) lives in the low slot, index 15 (mute) in the high slot.
   localparam logic [15:0][11:0] ATT_TABLE = {
      12'd0,    12'd163,  12'd205,  12'd258,
      12'd325,  12'd410,  12'd516,  12'd649,
      12'd817,  12'd1029, 12'd1295, 12'd1630,
      12'd2052, 12'd2584, 12'd3253, 12'd4095
   };

endpackage

// File: rtl/jt89_vol_ramp_if.sv
// Per-channel sample bus: enable, square bits and target volumes in, samples and busy flags out.
interface jt89_vol_ramp_if #(
   parameter int CH = 4,
   parameter int W  = 9
);
   logic                   clk_en;
   logic [CH-1:0]          din;
   logic [CH-1:0][3:0]     vol;
   logic [CH-1:0][W-1:0]   snd;
   logic [CH-1:0]          busy;

   modport master (output clk_en, din, vol, input snd, busy);
   modport slave  (input clk_en, din, vol, output snd, busy);
endinterface

// File: rtl/jt89_vol_ch.sv
// One channel: attenuation register stepping toward vol, table lookup, registered sample.
module jt89_vol_ch
   import jt89_pkg::*;
#(
   parameter int W       = 9,
   parameter int RAMP    = 16,
   parameter int BIPOLAR = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_en,
   input  logic         step,
   input  logic         din,
   input  logic [3:0]   vol,
   output logic [W-1:0] snd,
   output logic         busy
);
   // Bipolar spends one bit on the sign, so the magnitude is one bit narrower.
   localparam int M = (BIPOLAR != 0) ? W - 1 : W;

   logic [3:0]   att;
   logic [M-1:0] mag;
   logic [W-1:0] nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         att <= ATT_MUTE;
      else if (clk_en && (RAMP == 0 || step)) begin
         if (RAMP == 0)
            att <= vol;
         else if (att < vol)
            att <= att + 4'd1;
         else if (att > vol)
            att <= att - 4'd1;
      end
   end

   // Top M bits of the 12-bit entry are the entry shifted right by 12-M.
   assign mag = ATT_TABLE[att][11 -: M];

   generate
      if (BIPOLAR != 0) begin : g_bip
         assign nxt = din ? {1'b0, mag} : W'(0) - {1'b0, mag};
      end else begin : g_uni
         assign nxt = din ? mag : '0;
      end
   endgenerate

   // Sample uses att before this tick's step update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         snd <= '0;
      else if (clk_en)
         snd <= nxt;
   end

   assign busy = (att != vol);

endmodule

// File: rtl/jt89_vol_ramp.sv
// Volume ramp top: shared step prescaler plus CH independent channel slices.
module jt89_vol_ramp
   import jt89_pkg::*;
#(
   parameter int CH      = 4,
   parameter int W       = 9,
   parameter int RAMP    = 16,
   parameter int BIPOLAR = 0
) (
   input  logic clk,
   input  logic rst,
   jt89_vol_ramp_if.slave bus
);
   logic                 step;
   logic [CH-1:0][W-1:0] snd;
   logic [CH-1:0]        busy;

   generate
      if (RAMP > 1) begin : g_pre
         localparam int            PW   = $clog2(RAMP);
         localparam logic [PW-1:0] LAST = PW'(RAMP - 1);
         logic [PW-1:0] cnt;

         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               cnt <= '0;
            else if (bus.clk_en)
               cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
         end

         assign step = bus.clk_en && (cnt == LAST);
      end else if (RAMP == 1) begin : g_pre1
         assign step = bus.clk_en;
      end else begin : g_nopre
         // RAMP=0: channels load vol directly, step is never used.
         assign step = 1'b0;
      end
   endgenerate

   generate
      for (genvar n = 0; n < CH; n++) begin : g_ch
         jt89_vol_ch #(
            .W       (W),
            .RAMP    (RAMP),
            .BIPOLAR (BIPOLAR)
         ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .clk_en (bus.clk_en),
            .step   (step),
            .din    (bus.din[n]),
            .vol    (bus.vol[n]),
            .snd    (snd[n]),
            .busy   (busy[n])
         );
      end
   endgenerate

   assign bus.snd  = snd;
   assign bus.busy = busy;

endmodule
